mmc3_scanline_irq: RTL and testbench

//  MMC3-family scanline IRQ generator, consumed by MMC3-class mappers (mapper 4/191 style).

---
 rtl/mmc3_pkg.sv | 33 +++
 rtl/mmc3_a12_filter.sv | 86 ++++++++
 rtl/mmc3_scanline_irq.sv | 150 +++++++++++++++
 tb/tb_mmc3_scanline_irq.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmc3_pkg.sv
// rtl/mmc3_pkg.sv - shared decode constants and state types for the MMC3 scanline IRQ block
//
// Purpose: register decode keys for the $C000-$FFFF window, save-state offsets,
// and the packed IRQ flag group used by the top and the save-state interface.

package mmc3_pkg;

    // Decode key is {cpu_addr[15:13], cpu_addr[0]}.
    localparam logic [3:0] REG_C000 = 4'b1100;
    localparam logic [3:0] REG_C001 = 4'b1101;
    localparam logic [3:0] REG_E000 = 4'b1110;
    localparam logic [3:0] REG_E001 = 4'b1111;

    // Save-state address map.
    localparam logic [7:0] SS_RELOAD  = 8'd16;
    localparam logic [7:0] SS_COUNTER = 8'd17;
    localparam logic [7:0] SS_FLAGS   = 8'd18;
    localparam logic [7:0] SS_LOWCNT  = 8'd19;
    localparam logic [7:0] SS_ZERO_LO = 8'd20;
    localparam logic [7:0] SS_ZERO_HI = 8'd23;

    // Bit order matches the save-state flags byte bits [2:0].
    typedef struct packed {
        logic irq;
        logic reload_req;
        logic enable;
    } flags_t;

    function automatic logic [7:0] flags_byte(input flags_t f);
        return {5'b00000, f};
    endfunction

endpackage

// File: rtl/mmc3_a12_filter.sv
// rtl/mmc3_a12_filter.sv - M2/A12 synchronizers and the A12 low-time scanline filter
//
// Purpose: synchronizes m2 and ppu_a12 into clk, produces one-clk m2_fall and
// A12-rise strobes SYNC_STAGES+1 clks after the pin edge, and qualifies a rise as
// a scanline clock only after A12 has been low for A12_LOW_M2 m2 falling edges.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   m2, ppu_a12      asynchronous pin inputs
//   ss_act           save-state session: holds low_cnt, suppresses scan_clk
//   low_ld           load low_cnt from low_ld_val (save-state write)
//   low_ld_val       value to load; saturated to A12_LOW_M2
//   m2_fall          bus commit strobe
//   scan_clk         qualified scanline clock
//   low_cnt          current filter count, zero-extended

module mmc3_a12_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int A12_LOW_M2  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       m2,
    input  logic       ppu_a12,
    input  logic       ss_act,
    input  logic       low_ld,
    input  logic [7:0] low_ld_val,
    output logic       m2_fall,
    output logic       scan_clk,
    output logic [7:0] low_cnt
);

    localparam int                LOW_W    = $clog2(A12_LOW_M2 + 1);
    localparam logic [LOW_W-1:0]  LOW_MAX  = LOW_W'(A12_LOW_M2);
    localparam logic [7:0]        LOW_MAX8 = 8'(A12_LOW_M2);

    logic [SYNC_STAGES-1:0] m2_sync_q;
    logic [SYNC_STAGES-1:0] a12_sync_q;
    logic                   m2_prev_q;
    logic                   a12_prev_q;
    logic                   m2_fall_q;
    logic                   a12_rise_q;
    logic [LOW_W-1:0]       low_cnt_q;
    logic [LOW_W-1:0]       low_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m2_sync_q  <= '0;
            a12_sync_q <= '0;
            m2_prev_q  <= 1'b0;
            a12_prev_q <= 1'b0;
            m2_fall_q  <= 1'b0;
            a12_rise_q <= 1'b0;
            low_cnt_q  <= '0;
        end else begin
            // Truncating cast keeps the low bits: shift the pin in at bit 0.
            m2_sync_q  <= SYNC_STAGES'({m2_sync_q, m2});
            a12_sync_q <= SYNC_STAGES'({a12_sync_q, ppu_a12});
            m2_prev_q  <= m2_sync_q[SYNC_STAGES-1];
            a12_prev_q <= a12_sync_q[SYNC_STAGES-1];
            // Strobes are registered so both land SYNC_STAGES+1 clks after the pin edge.
            m2_fall_q  <= m2_prev_q & ~m2_sync_q[SYNC_STAGES-1];
            a12_rise_q <= ~a12_prev_q & a12_sync_q[SYNC_STAGES-1];
            low_cnt_q  <= low_cnt_d;
        end
    end

    // a12_prev_q is the A12 level aligned with the strobes: when a12_rise_q fires,
    // a12_prev_q is already high but low_cnt_q still holds the pre-rise count.
    always_comb begin
        low_cnt_d = low_cnt_q;
        if (ss_act) begin
            if (low_ld) begin
                low_cnt_d = (low_ld_val > LOW_MAX8) ? LOW_MAX : LOW_W'(low_ld_val);
            end
        end else if (a12_prev_q) begin
            low_cnt_d = '0;
        end else if (m2_fall_q && (low_cnt_q != LOW_MAX)) begin
            low_cnt_d = low_cnt_q + LOW_W'(1);
        end
    end

    assign m2_fall  = m2_fall_q;
    assign scan_clk = a12_rise_q & (low_cnt_q == LOW_MAX) & ~ss_act;
    assign low_cnt  = 8'(low_cnt_q);

endmodule

// File: rtl/mmc3_scanline_irq.sv
// rtl/mmc3_scanline_irq.sv - MMC3-family scanline counter and IRQ generator
//
// Purpose: decodes CPU writes to $C000-$FFFF, runs the 8-bit reload/decrement
// scanline counter clocked by filtered A12 rises, raises a level IRQ, and exposes
// counter state through a save-state read/write port.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   m2                   CPU M2 (async); its synchronized fall commits bus writes
//   cpu_addr/dat/rw      CPU bus, sampled at the m2_fall strobe
//   ppu_a12              PPU A12 (async), scanline clock source
//   mmc3a                1 = MMC3A zero-reload rules, 0 = MMC3B
//   ss_act/ss_we/ss_addr save-state session, write enable, address
//   irq                  IRQ pending level
//   ss_dout              save-state read data (combinational)

module mmc3_scanline_irq
    import mmc3_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int A12_LOW_M2  = 3,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m2,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dat,
    input  logic        cpu_rw,
    input  logic        ppu_a12,
    input  logic        mmc3a,
    input  logic        ss_act,
    input  logic        ss_we,
    input  logic [7:0]  ss_addr,
    output logic        irq,
    output logic [7:0]  ss_dout
);

    logic             m2_fall;
    logic             scan_clk;
    logic [7:0]       low_cnt;
    logic             cpu_wr;
    logic             ss_wr;
    logic [3:0]       wr_key;
    logic [CNT_W-1:0] reload_q, reload_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_new;
    flags_t           flags_q, flags_d;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^cpu_addr[12:1];

    assign cpu_wr = m2_fall & ~cpu_rw & ~ss_act;
    assign ss_wr  = m2_fall & ss_we & ss_act;
    assign wr_key = {cpu_addr[15:13], cpu_addr[0]};

    mmc3_a12_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .A12_LOW_M2 (A12_LOW_M2)
    ) u_a12_filter (
        .clk       (clk),
        .rst_n     (rst_n),
        .m2        (m2),
        .ppu_a12   (ppu_a12),
        .ss_act    (ss_act),
        .low_ld    (ss_wr && (ss_addr == SS_LOWCNT)),
        .low_ld_val(cpu_dat),
        .m2_fall   (m2_fall),
        .scan_clk  (scan_clk),
        .low_cnt   (low_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reload_q <= '0;
            cnt_q    <= '0;
            flags_q  <= '0;
        end else begin
            reload_q <= reload_d;
            cnt_q    <= cnt_d;
            flags_q  <= flags_d;
        end
    end

    // The scanline update is built from pre-write state; CPU write fields then
    // override it, so $C001 beats the counter update and $E000 beats an IRQ set.
    always_comb begin
        reload_d = reload_q;
        cnt_d    = cnt_q;
        flags_d  = flags_q;
        cnt_new  = '0;

        if (scan_clk) begin
            if ((cnt_q == '0) || flags_q.reload_req) begin
                cnt_new            = reload_q;
                flags_d.reload_req = 1'b0;
            end else begin
                cnt_new = cnt_q - CNT_W'(1);
            end
            cnt_d = cnt_new;
            // MMC3A only fires on a transition into zero; MMC3B fires whenever zero.
            if ((cnt_new == '0) && flags_q.enable &&
                (!mmc3a || (cnt_q != '0) || flags_q.reload_req)) begin
                flags_d.irq = 1'b1;
            end
        end

        if (cpu_wr) begin
            case (wr_key)
                REG_C000: reload_d = CNT_W'(cpu_dat);
                REG_C001: begin
                    cnt_d              = '0;
                    flags_d.reload_req = 1'b1;
                end
                REG_E000: begin
                    flags_d.enable = 1'b0;
                    flags_d.irq    = 1'b0;
                end
                REG_E001: flags_d.enable = 1'b1;
                default:  ;
            endcase
        end

        if (ss_wr) begin
            case (ss_addr)
                SS_RELOAD:  reload_d = CNT_W'(cpu_dat);
                SS_COUNTER: cnt_d    = CNT_W'(cpu_dat);
                SS_FLAGS:   flags_d  = flags_t'(cpu_dat[2:0]);
                default:    ;
            endcase
        end
    end

    always_comb begin
        ss_dout = 8'hFF;
        case (ss_addr)
            SS_RELOAD:  ss_dout = 8'(reload_q);
            SS_COUNTER: ss_dout = 8'(cnt_q);
            SS_FLAGS:   ss_dout = flags_byte(flags_q);
            SS_LOWCNT:  ss_dout = low_cnt;
            default: begin
                if ((ss_addr >= SS_ZERO_LO) && (ss_addr <= SS_ZERO_HI)) begin
                    ss_dout = 8'h00;
                end
            end
        endcase
    end

    assign irq = flags_q.irq;

endmodule

// File: tb/tb_mmc3_scanline_irq.sv
// tb/tb_mmc3_scanline_irq.sv - directed self-checking bench for mmc3_scanline_irq

module tb_mmc3_scanline_irq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m2 = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_dat = 8'h00;
    logic        cpu_rw = 1'b1;
    logic        ppu_a12 = 1'b0;
    logic        mmc3a = 1'b0;
    logic        ss_act = 1'b0;
    logic        ss_we = 1'b0;
    logic [7:0]  ss_addr = 8'h00;
    logic        irq;
    logic [7:0]  ss_dout;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mmc3_scanline_irq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .m2      (m2),
        .cpu_addr(cpu_addr),
        .cpu_dat (cpu_dat),
        .cpu_rw  (cpu_rw),
        .ppu_a12 (ppu_a12),
        .mmc3a   (mmc3a),
        .ss_act  (ss_act),
        .ss_we   (ss_we),
        .ss_addr (ss_addr),
        .irq     (irq),
        .ss_dout (ss_dout)
    );

    initial begin
        #1ms;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1);
    end

    task automatic peek(input logic [7:0] a, output logic [7:0] v);
        ss_addr = a;
        #1;
        v = ss_dout;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; m2 = 1'b0; cpu_rw = 1'b1; ss_act = 1'b0; ss_we = 1'b0;
        cpu_addr = 16'h0000; cpu_dat = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ppu_a12 = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw);
        @(negedge clk);
        cpu_addr = a; cpu_dat = d; cpu_rw = rw; m2 = 1'b1;
        repeat (4) @(negedge clk);
        m2 = 1'b0;
        repeat (6) @(negedge clk);
        cpu_rw = 1'b1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        cpu_cycle(a, d, 1'b0);
    endtask

    task automatic scanline(input int nlow);
        @(negedge clk);
        ppu_a12 = 1'b1;
        repeat (6) @(negedge clk);
        ppu_a12 = 1'b0;
        repeat (nlow) cpu_cycle(16'h0000, 8'h00, 1'b1);
        @(negedge clk);
        ppu_a12 = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] v;
        logic [7:0] addrs [8];
        logic [7:0] exps  [8];
        addrs = '{8'd16, 8'd17, 8'd18, 8'd19, 8'd20, 8'd23, 8'd24, 8'd15};
        exps  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF};
        apply_reset();
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_irq got=%b exp=0", irq);
        end
        for (int i = 0; i < 8; i++) begin
            peek(addrs[i], v);
            checks++;
            if (v !== exps[i]) begin
                failures++;
                $display("FAIL reset_ss_%0d got=%02h exp=%02h", addrs[i], v, exps[i]);
            end
        end
    endtask

    task automatic test_counter();
        logic [7:0] v;
        logic [7:0] exp_cnt [5];
        logic       exp_irq [5];
        exp_cnt = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd3};
        exp_irq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        mmc3a = 1'b0;
        apply_reset();
        wr(16'hC000, 8'd3);
        wr(16'hC001, 8'h00);
        wr(16'hE001, 8'h00);
        peek(8'd18, v);
        checks++;
        if (v !== 8'h03) begin
            failures++;
            $display("FAIL counter_flags_setup got=%02h exp=03", v);
        end
        for (int i = 0; i < 5; i++) begin
            scanline(3);
            peek(8'd17, v);
            checks++;
            if (v !== exp_cnt[i] || irq !== exp_irq[i]) begin
                failures++;
                $display("FAIL counter_rise%0d cnt=%0d irq=%b exp_cnt=%0d exp_irq=%b",
                         i + 1, v, irq, exp_cnt[i], exp_irq[i]);
            end
        end
    endtask

    task automatic test_a12_filter();
        logic [7:0] v;
        wr(16'hE000, 8'h00);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL e000_clear_irq got=%b exp=0", irq);
        end
        scanline(2);
        peek(8'd17, v);
        checks++;
        if (v !== 8'd3 || irq !== 1'b0) begin
            failures++;
            $display("FAIL filter_short_low cnt=%0d irq=%b exp_cnt=3 exp_irq=0", v, irq);
        end
        scanline(3);
        peek(8'd17, v);
        checks++;
        if (v !== 8'd2) begin
            failures++;
            $display("FAIL filter_full_low cnt=%0d exp=2", v);
        end
    endtask

    task automatic test_zero_reload();
        logic [7:0] v;
        mmc3a = 1'b0;
        apply_reset();
        wr(16'hC000, 8'd0);
        wr(16'hE001, 8'h00);
        scanline(3);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL mmc3b_zero_first got=%b exp=1", irq);
        end
        wr(16'hE000, 8'h00);
        wr(16'hE001, 8'h00);
        scanline(3);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL mmc3b_zero_repeat got=%b exp=1", irq);
        end

        mmc3a = 1'b1;
        apply_reset();
        wr(16'hC000, 8'd0);
        wr(16'hE001, 8'h00);
        for (int i = 0; i < 3; i++) begin
            scanline(3);
            peek(8'd17, v);
            checks++;
            if (irq !== 1'b0 || v !== 8'd0) begin
                failures++;
                $display("FAIL mmc3a_zero_rise%0d irq=%b cnt=%0d exp_irq=0 exp_cnt=0", i + 1, irq, v);
            end
        end
        wr(16'hC001, 8'h00);
        scanline(3);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL mmc3a_after_c001 got=%b exp=1", irq);
        end
        wr(16'hE000, 8'h00);
        wr(16'hE001, 8'h00);
        scanline(3);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL mmc3a_once_only got=%b exp=0", irq);
        end
        mmc3a = 1'b0;
    endtask

    task automatic test_same_clk_e000();
        logic [7:0] v;
        logic [7:0] f;
        mmc3a = 1'b0;
        apply_reset();
        wr(16'hC000, 8'd0);
        wr(16'hE001, 8'h00);
        scanline(3);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL same_clk_setup_irq got=%b exp=1", irq);
        end
        // Arm the filter, then let the m2 fall and the A12 rise strobe together.
        @(negedge clk);
        ppu_a12 = 1'b1;
        repeat (6) @(negedge clk);
        ppu_a12 = 1'b0;
        repeat (3) cpu_cycle(16'h0000, 8'h00, 1'b1);
        @(negedge clk);
        cpu_addr = 16'hE000; cpu_dat = 8'h00; cpu_rw = 1'b0; m2 = 1'b1;
        repeat (4) @(negedge clk);
        m2 = 1'b0;
        ppu_a12 = 1'b1;
        repeat (6) @(negedge clk);
        cpu_rw = 1'b1;
        peek(8'd17, v);
        peek(8'd18, f);
        checks++;
        if (irq !== 1'b0 || v !== 8'd0 || f !== 8'h00) begin
            failures++;
            $display("FAIL same_clk_e000 irq=%b cnt=%0d flags=%02h exp irq=0 cnt=0 flags=00", irq, v, f);
        end
        scanline(3);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL disabled_no_irq got=%b exp=0", irq);
        end
    endtask

    task automatic test_save_state();
        logic [7:0] v;
        logic [7:0] addrs [6];
        logic [7:0] exps  [6];
        logic [7:0] wa    [3];
        logic [7:0] wd    [3];
        addrs = '{8'd16, 8'd17, 8'd18, 8'd19, 8'd20, 8'd40};
        exps  = '{8'h20, 8'h05, 8'h05, 8'h00, 8'h00, 8'hFF};
        wa    = '{8'd16, 8'd17, 8'd18};
        wd    = '{8'h20, 8'h05, 8'h05};
        apply_reset();
        wr(16'hC000, 8'd3);
        wr(16'hC001, 8'h00);
        wr(16'hE001, 8'h00);
        ss_act = 1'b1;
        ss_we  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ss_addr = wa[i];
            wr(16'hC000, wd[i]);
        end
        ss_we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            peek(addrs[i], v);
            checks++;
            if (v !== exps[i]) begin
                failures++;
                $display("FAIL ss_read_%0d got=%02h exp=%02h", addrs[i], v, exps[i]);
            end
        end
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL ss_irq_restored got=%b exp=1", irq);
        end
        ss_act = 1'b0;
        scanline(3);
        peek(8'd17, v);
        checks++;
        if (v !== 8'd4 || irq !== 1'b1) begin
            failures++;
            $display("FAIL ss_resume cnt=%0d irq=%b exp_cnt=4 exp_irq=1", v, irq);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] v;
        logic [7:0] f;
        @(negedge clk);
        ppu_a12 = 1'b0;
        repeat (3) cpu_cycle(16'h0000, 8'h00, 1'b1);
        peek(8'd19, v);
        checks++;
        if (v !== 8'd3) begin
            failures++;
            $display("FAIL low_cnt_saturated got=%0d exp=3", v);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_irq got=%b exp=0", irq);
        end
        peek(8'd17, v);
        peek(8'd19, f);
        checks++;
        if (v !== 8'd0 || f !== 8'd0) begin
            failures++;
            $display("FAIL async_reset_state cnt=%0d low=%0d exp 0 0", v, f);
        end
        ppu_a12 = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        wr(16'hC000, 8'd2);
        wr(16'hC001, 8'h00);
        wr(16'hE001, 8'h00);
        // A12 drops and rises with no m2 fall in between: must not count.
        @(negedge clk);
        ppu_a12 = 1'b0;
        repeat (6) @(negedge clk);
        ppu_a12 = 1'b1;
        repeat (6) @(negedge clk);
        peek(8'd17, v);
        peek(8'd18, f);
        checks++;
        if (v !== 8'd0 || f !== 8'h03) begin
            failures++;
            $display("FAIL post_reset_rise_ignored cnt=%0d flags=%02h exp cnt=0 flags=03", v, f);
        end
        scanline(3);
        peek(8'd17, v);
        checks++;
        if (v !== 8'd2) begin
            failures++;
            $display("FAIL post_reset_first_count cnt=%0d exp=2", v);
        end
    endtask

    initial begin
        test_reset();
        test_counter();
        test_a12_filter();
        test_zero_reload();
        test_same_clk_e000();
        test_save_state();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
